// File: rtl/filter_rank_3x3.sv
// filter_rank_3x3
//  Multi-channel 3x3 rank-order filter (median / min / max) on a de/hs/vs video stream.
//  Two line buffers feed a 3x3 window; ranking is a 4-clock pipeline from the pixel that
//  completes a window to de_o.
//  Optional build macro: FILTER_RANK_STAT_EN adds the stat_pix / stat_line frame statistics.
module filter_rank_3x3 #(
   parameter int LINE_SIZE_MAX = 4096,
   parameter int PIXEL_WIDTH   = 8,
   parameter int CHANNELS      = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            bypass,
   input  logic [1:0]                      mode,
   input  logic [CHANNELS*PIXEL_WIDTH-1:0] di_i,
   input  logic                            de_i,
   input  logic                            hs_i,
   input  logic                            vs_i,
   output logic [CHANNELS*PIXEL_WIDTH-1:0] do_o,
   output logic                            de_o,
   output logic                            hs_o,
   output logic                            vs_o,
   output logic [CHANNELS*PIXEL_WIDTH-1:0] bypass_o
`ifdef FILTER_RANK_STAT_EN
   ,
   output logic [31:0]                     stat_pix,
   output logic [15:0]                     stat_line
`endif
);

   localparam int PW    = PIXEL_WIDTH;
   localparam int CW    = CHANNELS * PIXEL_WIDTH;
   localparam int AW    = (LINE_SIZE_MAX > 1) ? $clog2(LINE_SIZE_MAX) : 1;
   localparam int CNT_W = AW + 1;
   localparam logic [CNT_W-1:0] LINE_END = CNT_W'(LINE_SIZE_MAX);

   // unsigned compare helpers for one channel
   function automatic logic [PW-1:0] min2(input logic [PW-1:0] a, input logic [PW-1:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [PW-1:0] max2(input logic [PW-1:0] a, input logic [PW-1:0] b);
      return (a < b) ? b : a;
   endfunction

   function automatic logic [PW-1:0] min3(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                          input logic [PW-1:0] c);
      return min2(min2(a, b), c);
   endfunction

   function automatic logic [PW-1:0] max3(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                          input logic [PW-1:0] c);
      return max2(max2(a, b), c);
   endfunction

   function automatic logic [PW-1:0] med3(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                          input logic [PW-1:0] c);
      return max2(min2(a, b), min2(max2(a, b), c));
   endfunction

   typedef enum logic {WAIT_VS = 1'b0, ACTIVE = 1'b1} state_t;

   state_t             state, state_nxt;
   logic               vs_q, hs_q;
   logic               vs_rise, vs_fall, hs_rise;
   logic               frame_start, pix_acc, win_vld;
   logic [1:0]         mode_q;
   logic               bypass_q;
   logic [CNT_W-1:0]   col_cnt, col_nxt;
   logic [1:0]         row_cnt;       // saturates at 2: only "two rows above exist" matters
   logic               line_has_de;
   logic [AW-1:0]      rd_addr, wr_addr;
   logic [CW-1:0]      ram0 [LINE_SIZE_MAX];
   logic [CW-1:0]      ram1 [LINE_SIZE_MAX];
   logic [CW-1:0]      rd0, rd1;
   logic [CW-1:0]      col_lo, col_md, col_hi;
   logic [2:0][CW-1:0] lo_p0, md_p0, hi_p0;
   logic [CW-1:0]      rm_p0, cen_p0;
   logic               vld_p0, hs_p0, vs_p0;
   logic [CW-1:0]      mxlo_s2, mdmd_s2, mnhi_s2, mnlo_s2, mxhi_s2;
   logic [CW-1:0]      mxlo_p1, mdmd_p1, mnhi_p1, mnlo_p1, mxhi_p1, cen_p1;
   logic               vld_p1, hs_p1, vs_p1;
   logic [CW-1:0]      med_s3;
   logic [CW-1:0]      med_p2, min_p2, max_p2, cen_p2;
   logic               vld_p2, hs_p2, vs_p2;
   logic [CW-1:0]      res_s4;

   assign vs_rise = vs_i & ~vs_q;
   assign vs_fall = ~vs_i & vs_q;
   assign hs_rise = hs_i & ~hs_q;

   // sync edge history; reset to the "frame/blank in progress" levels so a frame already
   // running when reset releases is not mistaken for a new one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q <= 1'b1;
         hs_q <= 1'b1;
      end else begin
         vs_q <= vs_i;
         hs_q <= hs_i;
      end
   end

   // frame FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= WAIT_VS;
      else        state <= state_nxt;
   end

   // frame FSM next state
   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_VS: if (vs_rise) state_nxt = ACTIVE;
         ACTIVE:  if (vs_fall) state_nxt = WAIT_VS;
         default: state_nxt = WAIT_VS;
      endcase
   end

   // frame FSM outputs: frame start strobe and accepted-pixel strobe (overlong lines dropped)
   always_comb begin
      frame_start = 1'b0;
      pix_acc     = 1'b0;
      case (state)
         WAIT_VS: frame_start = vs_rise;
         ACTIVE:  pix_acc = vs_i & de_i & ~hs_rise & (col_cnt < LINE_END);
         default: begin end
      endcase
   end

   assign win_vld = pix_acc & (col_cnt >= CNT_W'(2)) & (row_cnt == 2'd2);

   // per-frame settings, frozen at frame start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q   <= 2'b00;
         bypass_q <= 1'b0;
      end else if (frame_start) begin
         mode_q   <= mode;
         bypass_q <= bypass;
      end
   end

   // column index the next cycle will see; also used as the look-ahead RAM read address
   always_comb begin
      col_nxt = col_cnt;
      if (frame_start || hs_rise) col_nxt = '0;
      else if (pix_acc)           col_nxt = col_cnt + 1'b1;
   end

   assign rd_addr = (col_nxt < LINE_END) ? col_nxt[AW-1:0] : '0;
   assign wr_addr = col_cnt[AW-1:0];

   // column / row counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_cnt     <= '0;
         row_cnt     <= 2'd0;
         line_has_de <= 1'b0;
      end else begin
         col_cnt <= col_nxt;
         if (frame_start) begin
            row_cnt     <= 2'd0;
            line_has_de <= 1'b0;
         end else if (hs_rise) begin
            line_has_de <= 1'b0;
            if (line_has_de && row_cnt != 2'd2) row_cnt <= row_cnt + 1'b1;
         end else if (pix_acc) begin
            line_has_de <= 1'b1;
         end
      end
   end

   // line buffers: read one column ahead so rd0/rd1 hold rows y-1/y-2 when the pixel arrives
   always_ff @(posedge clk) begin
      if (pix_acc) begin
         ram0[wr_addr] <= di_i;
         ram1[wr_addr] <= rd0;
      end
      rd0 <= ram0[rd_addr];
      rd1 <= ram1[rd_addr];
   end

   // sort the incoming column per channel
   always_comb begin
      col_lo = '0;
      col_md = '0;
      col_hi = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         col_lo[k*PW +: PW] = min3(rd1[k*PW +: PW], rd0[k*PW +: PW], di_i[k*PW +: PW]);
         col_md[k*PW +: PW] = med3(rd1[k*PW +: PW], rd0[k*PW +: PW], di_i[k*PW +: PW]);
         col_hi[k*PW +: PW] = max3(rd1[k*PW +: PW], rd0[k*PW +: PW], di_i[k*PW +: PW]);
      end
   end

   // S1: shift the sorted column into the window on each accepted pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_p0  <= '0;
         md_p0  <= '0;
         hi_p0  <= '0;
         rm_p0  <= '0;
         cen_p0 <= '0;
         vld_p0 <= 1'b0;
         hs_p0  <= 1'b1;
         vs_p0  <= 1'b0;
      end else begin
         vld_p0 <= win_vld;
         hs_p0  <= hs_i;
         vs_p0  <= vs_i;
         if (pix_acc) begin
            lo_p0  <= {col_lo, lo_p0[2], lo_p0[1]};
            md_p0  <= {col_md, md_p0[2], md_p0[1]};
            hi_p0  <= {col_hi, hi_p0[2], hi_p0[1]};
            rm_p0  <= rd0;
            cen_p0 <= rm_p0;
         end
      end
   end

   // cross-column reduction per channel
   always_comb begin
      mxlo_s2 = '0;
      mdmd_s2 = '0;
      mnhi_s2 = '0;
      mnlo_s2 = '0;
      mxhi_s2 = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         mxlo_s2[k*PW +: PW] = max3(lo_p0[0][k*PW +: PW], lo_p0[1][k*PW +: PW], lo_p0[2][k*PW +: PW]);
         mdmd_s2[k*PW +: PW] = med3(md_p0[0][k*PW +: PW], md_p0[1][k*PW +: PW], md_p0[2][k*PW +: PW]);
         mnhi_s2[k*PW +: PW] = min3(hi_p0[0][k*PW +: PW], hi_p0[1][k*PW +: PW], hi_p0[2][k*PW +: PW]);
         mnlo_s2[k*PW +: PW] = min3(lo_p0[0][k*PW +: PW], lo_p0[1][k*PW +: PW], lo_p0[2][k*PW +: PW]);
         mxhi_s2[k*PW +: PW] = max3(hi_p0[0][k*PW +: PW], hi_p0[1][k*PW +: PW], hi_p0[2][k*PW +: PW]);
      end
   end

   // S2: register cross-column results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mxlo_p1 <= '0;
         mdmd_p1 <= '0;
         mnhi_p1 <= '0;
         mnlo_p1 <= '0;
         mxhi_p1 <= '0;
         cen_p1  <= '0;
         vld_p1  <= 1'b0;
         hs_p1   <= 1'b1;
         vs_p1   <= 1'b0;
      end else begin
         mxlo_p1 <= mxlo_s2;
         mdmd_p1 <= mdmd_s2;
         mnhi_p1 <= mnhi_s2;
         mnlo_p1 <= mnlo_s2;
         mxhi_p1 <= mxhi_s2;
         cen_p1  <= cen_p0;
         vld_p1  <= vld_p0;
         hs_p1   <= hs_p0;
         vs_p1   <= vs_p0;
      end
   end

   // final median of the three candidates per channel
   always_comb begin
      med_s3 = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         med_s3[k*PW +: PW] = med3(mxlo_p1[k*PW +: PW], mdmd_p1[k*PW +: PW], mnhi_p1[k*PW +: PW]);
      end
   end

   // S3: register median, min and max
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         med_p2 <= '0;
         min_p2 <= '0;
         max_p2 <= '0;
         cen_p2 <= '0;
         vld_p2 <= 1'b0;
         hs_p2  <= 1'b1;
         vs_p2  <= 1'b0;
      end else begin
         med_p2 <= med_s3;
         min_p2 <= mnlo_p1;
         max_p2 <= mxhi_p1;
         cen_p2 <= cen_p1;
         vld_p2 <= vld_p1;
         hs_p2  <= hs_p1;
         vs_p2  <= vs_p1;
      end
   end

   // rank / bypass select with the settings frozen for this frame
   always_comb begin
      res_s4 = med_p2;
      if (bypass_q)               res_s4 = cen_p2;
      else if (mode_q == 2'b01)   res_s4 = min_p2;
      else if (mode_q == 2'b10)   res_s4 = max_p2;
   end

   // S4: output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         do_o     <= '0;
         bypass_o <= '0;
         de_o     <= 1'b0;
         hs_o     <= 1'b1;
         vs_o     <= 1'b0;
      end else begin
         do_o     <= res_s4;
         bypass_o <= cen_p2;
         de_o     <= vld_p2;
         hs_o     <= hs_p2;
         vs_o     <= vs_p2;
      end
   end

`ifdef FILTER_RANK_STAT_EN
   logic        vs_o_q, hs_o_q, oline_has_de;
   logic [31:0] pix_cnt;
   logic [15:0] line_cnt;

   // output-side statistics, latched and cleared when vs_o falls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_o_q       <= 1'b0;
         hs_o_q       <= 1'b1;
         oline_has_de <= 1'b0;
         pix_cnt      <= '0;
         line_cnt     <= '0;
         stat_pix     <= '0;
         stat_line    <= '0;
      end else begin
         vs_o_q <= vs_o;
         hs_o_q <= hs_o;
         if (vs_o_q && !vs_o) begin
            stat_pix     <= pix_cnt;
            stat_line    <= line_cnt + {15'd0, oline_has_de};
            pix_cnt      <= '0;
            line_cnt     <= '0;
            oline_has_de <= 1'b0;
         end else begin
            if (de_o) pix_cnt <= pix_cnt + 32'd1;
            if (hs_o && !hs_o_q) begin
               oline_has_de <= 1'b0;
               if (oline_has_de) line_cnt <= line_cnt + 16'd1;
            end else if (de_o) begin
               oline_has_de <= 1'b1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_filter_rank_3x3.sv
// tb_filter_rank_3x3
//  Directed frames for filter_rank_3x3 (3 channels, 8-bit, short line buffers).
//  Stat outputs are connected and checked only when FILTER_RANK_STAT_EN is defined.
module tb_filter_rank_3x3;

   localparam int LSM = 20;
   localparam int PW  = 8;
   localparam int CH  = 3;
   localparam int CW  = CH * PW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          bypass;
   logic [1:0]    mode;
   logic [CW-1:0] di_i;
   logic          de_i, hs_i, vs_i;
   logic [CW-1:0] do_o, bypass_o;
   logic          de_o, hs_o, vs_o;
`ifdef FILTER_RANK_STAT_EN
   logic [31:0]   stat_pix;
   logic [15:0]   stat_line;
`endif

   filter_rank_3x3 #(.LINE_SIZE_MAX(LSM), .PIXEL_WIDTH(PW), .CHANNELS(CH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bypass   (bypass),
      .mode     (mode),
      .di_i     (di_i),
      .de_i     (de_i),
      .hs_i     (hs_i),
      .vs_i     (vs_i),
      .do_o     (do_o),
      .de_o     (de_o),
      .hs_o     (hs_o),
      .vs_o     (vs_o),
      .bypass_o (bypass_o)
`ifdef FILTER_RANK_STAT_EN
      ,
      .stat_pix (stat_pix),
      .stat_line(stat_line)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [CW-1:0] val;
      logic [CW-1:0] cen;
      int            cyc;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          mon_e;
   int            n_cmp = 0;
   int            n_err = 0;
   int            n_exp = 0;
   int            n_got = 0;
   int            n_ff  = 0;
   logic [CW-1:0] first_out;
   logic [CW-1:0] img [0:19][0:23];
   logic [1:0]    f_mode;
   logic          f_byp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
      end
   endtask

   // reference: full sort of the 9 window values per channel
   function automatic logic [CW-1:0] golden(input int x, input int y, input logic [1:0] md,
                                            input logic byp);
      logic [CW-1:0] r;
      logic [PW-1:0] v [9];
      logic [PW-1:0] t;
      int            n;
      r = '0;
      for (int ch = 0; ch < CH; ch++) begin
         n = 0;
         for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++) begin
               v[n] = img[y+dy][x+dx][ch*PW +: PW];
               n++;
            end
         for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
               if (v[j] > v[j+1]) begin
                  t = v[j]; v[j] = v[j+1]; v[j+1] = t;
               end
         if (byp)                r[ch*PW +: PW] = img[y+1][x+1][ch*PW +: PW];
         else if (md == 2'b01)   r[ch*PW +: PW] = v[0];
         else if (md == 2'b10)   r[ch*PW +: PW] = v[8];
         else                    r[ch*PW +: PW] = v[4];
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_ramp(input int w);
      logic [7:0] r;
      for (int y = 0; y < 20; y++)
         for (int x = 0; x < 24; x++) begin
            r = 8'(x + w * y);
            img[y][x] = {~r, 8'hAA, r};
         end
   endtask

   task automatic load_spike();
      for (int y = 0; y < 20; y++)
         for (int x = 0; x < 24; x++) img[y][x] = {3{8'h40}};
      img[3][3] = {3{8'hFF}};
   endtask

   task automatic send_line(input int y, input int w, input int gap, input bit push);
      hs_i = 1'b0;
      tick(); tick();
      for (int x = 0; x < w; x++) begin
         de_i = 1'b1;
         di_i = img[y][x];
         if (push && x >= 2 && y >= 2 && x < LSM) begin
            exp_t e;
            e.val = golden(x - 2, y - 2, f_mode, f_byp);
            e.cen = img[y-1][x-1];
            e.cyc = cyc + 4;
            exp_q.push_back(e);
            n_exp++;
         end
         tick();
         de_i = 1'b0;
         repeat (gap) tick();
      end
      tick();
      hs_i = 1'b1;
      tick(); tick(); tick();
   endtask

   task automatic frame_begin(input logic [1:0] md, input logic byp);
      mode = md; bypass = byp; f_mode = md; f_byp = byp;
      n_exp = 0; n_got = 0; n_ff = 0; first_out = '0;
      vs_i = 1'b1;
      tick(); tick();
   endtask

   task automatic frame_end(input string tag);
      vs_i = 1'b0;
      repeat (10) tick();
      chk({tag, "_count"}, 32'(n_got), 32'(n_exp));
      chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic run_frame(input string tag, input int w, input int h, input int gap,
                            input logic [1:0] md, input logic byp);
      frame_begin(md, byp);
      for (int y = 0; y < h; y++) send_line(y, w, gap, 1'b1);
      frame_end(tag);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_do"}, 32'(do_o), 32'd0);
      chk({tag, "_byp"}, 32'(bypass_o), 32'd0);
      chk({tag, "_de"}, 32'(de_o), 32'd0);
      chk({tag, "_hs"}, 32'(hs_o), 32'd1);
      chk({tag, "_vs"}, 32'(vs_o), 32'd0);
   endtask

   // output monitor: every de_o must match the next expected window, value and timing
   always @(negedge clk) begin
      if (rst_n && de_o) begin
         n_got++;
         if (n_got == 1) first_out = do_o;
         if (do_o[7:0] == 8'hFF) n_ff++;
         if (exp_q.size() == 0) begin
            chk("de_o_spurious", 32'(de_o), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("do_o", 32'(do_o), 32'(mon_e.val));
            chk("bypass_o", 32'(bypass_o), 32'(mon_e.cen));
            chk("latency", 32'(cyc), 32'(mon_e.cyc));
            chk("hs_o_align", 32'(hs_o), 32'd0);
            chk("vs_o_align", 32'(vs_o), 32'd1);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; bypass = 1'b0; mode = 2'b00; di_i = '0;
      de_i = 1'b0; hs_i = 1'b1; vs_i = 1'b0;
      tick(); tick(); tick();
      chk_reset_outputs("rst");
      rst_n = 1'b1;
      tick(); tick();

      // ramp, median: output equals input(x+1,y+1)
      load_ramp(8);
      run_frame("ramp_med", 8, 8, 0, 2'b00, 1'b0);
      chk("ramp_med_first", 32'(first_out), 32'h00F6AA09);

      // ramp, min: ch0=min, ch1 constant, ch2=~max
      run_frame("ramp_min", 8, 8, 0, 2'b01, 1'b0);
      chk("ramp_min_first", 32'(first_out), 32'h00EDAA00);

      // single bright pixel: removed by median, spread over 9 outputs by max
      load_spike();
      run_frame("spike_med", 8, 8, 0, 2'b00, 1'b0);
      chk("spike_med_ff", 32'(n_ff), 32'd0);
      run_frame("spike_max", 8, 8, 0, 2'b10, 1'b0);
      chk("spike_max_ff", 32'(n_ff), 32'd9);

      // 16x16 with and without input gaps
      load_ramp(16);
      run_frame("gap0", 16, 16, 0, 2'b00, 1'b0);
      chk("gap0_n", 32'(n_got), 32'd196);
      run_frame("gap3", 16, 16, 3, 2'b00, 1'b0);
      chk("gap3_n", 32'(n_got), 32'd196);

      // bypass: centre pixel regardless of mode
      load_ramp(8);
      run_frame("bypass", 8, 8, 0, 2'b10, 1'b1);
      chk("bypass_first", 32'(first_out), 32'h00F6AA09);

      // too few lines / too few pixels per line
      run_frame("short_h", 8, 2, 0, 2'b00, 1'b0);
      run_frame("short_w", 2, 8, 0, 2'b00, 1'b0);

      // lines longer than the line buffer: pixels beyond it are dropped
      load_ramp(22);
      run_frame("overlong", 22, 3, 0, 2'b00, 1'b0);
      chk("overlong_n", 32'(n_got), 32'd18);

      // reset asserted mid-line, released mid-frame
      load_ramp(8);
      frame_begin(2'b00, 1'b0);
      for (int y = 0; y < 3; y++) send_line(y, 8, 0, 1'b1);
      chk("pre_rst_count", 32'(n_got), 32'(n_exp));
      hs_i = 1'b0;
      tick(); tick();
      for (int x = 0; x < 4; x++) begin
         de_i = 1'b1; di_i = img[3][x];
         tick();
      end
      de_i = 1'b0;
      rst_n = 1'b0;
      exp_q.delete();
      n_exp = 0; n_got = 0;
      tick(); tick();
      chk_reset_outputs("midrst");
      rst_n = 1'b1;
      for (int x = 4; x < 8; x++) begin
         de_i = 1'b1; di_i = img[3][x];
         tick();
      end
      de_i = 1'b0;
      tick();
      hs_i = 1'b1;
      tick(); tick();
      for (int y = 4; y < 8; y++) send_line(y, 8, 0, 1'b0);
      frame_end("rst_frame");
      run_frame("post_rst", 8, 8, 0, 2'b00, 1'b0);
      chk("post_rst_first", 32'(first_out), 32'h00F6AA09);

      // mode change mid-frame takes effect only at the next frame
      frame_begin(2'b00, 1'b0);
      for (int y = 0; y < 8; y++) begin
         if (y == 4) mode = 2'b10;
         send_line(y, 8, 0, 1'b1);
      end
      frame_end("toggle_med");
      chk("toggle_med_first", 32'(first_out), 32'h00F6AA09);
`ifdef FILTER_RANK_STAT_EN
      chk("stat_pix", stat_pix, 32'd36);
      chk("stat_line", 32'(stat_line), 32'd6);
`endif
      run_frame("toggle_max", 8, 8, 0, 2'b10, 1'b0);
      chk("toggle_max_first", 32'(first_out), 32'h00FFAA12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
